// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: first-word fall-through FIFO capturing retired-instruction commit records
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   flush_in                 empties the FIFO on the next edge (overflow state kept)
//   commit_*_in              one commit record per cycle when commit_valid_in=1
//   trace_valid_out/ready_in head-record handshake toward the monitor
//   trace_*_out              head record fields, zero while empty
//   count_out                occupancy
//   overflow_out             sticky flag, a commit was dropped because the FIFO was full
//   dropped_out              saturating count of dropped commits
module commit_trace_buffer #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 16,
    parameter int FILTER_NOWRITE = 0,
    parameter int DROP_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_in,
    input  logic                     commit_valid_in,
    input  logic [WIDTH-1:0]         commit_pc_in,
    input  logic [5:0]               commit_opcode_in,
    input  logic [4:0]               commit_rd_in,
    input  logic [WIDTH-1:0]         commit_data_in,
    input  logic                     commit_we_in,
    output logic                     trace_valid_out,
    input  logic                     trace_ready_in,
    output logic [WIDTH-1:0]         trace_pc_out,
    output logic [5:0]               trace_opcode_out,
    output logic [4:0]               trace_rd_out,
    output logic [WIDTH-1:0]         trace_data_out,
    output logic                     trace_we_out,
    output logic                     trace_check_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out,
    output logic [DROP_W-1:0]        dropped_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [5:0] CHECK_OP = 6'b111111;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [5:0]       op;
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
        logic             we;
        logic             chk;
    } rec_t;

    rec_t              r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              r_overflow;
    logic [DROP_W-1:0] r_dropped;

    logic w_is_check;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_write;
    logic w_drop;
    rec_t w_head;

    assign w_is_check = commit_opcode_in == CHECK_OP;
    assign w_empty    = r_wr_ptr == r_rd_ptr;
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push     = commit_valid_in && (FILTER_NOWRITE == 0 || commit_we_in || w_is_check);
    assign w_pop      = !w_empty && trace_ready_in && !flush_in;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_write    = w_push && !flush_in && (!w_full || w_pop);
    assign w_drop     = w_push && !flush_in && w_full && !w_pop;
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_write && !rst)
            r_mem[r_wr_ptr[AW-1:0]] <= '{pc: commit_pc_in, op: commit_opcode_in, rd: commit_rd_in,
                                         data: commit_data_in, we: commit_we_in, chk: w_is_check};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (flush_in) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
            if (w_drop && r_dropped != '1) r_dropped <= r_dropped + 1'b1;
        end
    end

    // head fields are forced to zero while empty so stale storage never shows
    assign trace_valid_out  = !w_empty;
    assign trace_pc_out     = w_empty ? '0 : w_head.pc;
    assign trace_opcode_out = w_empty ? '0 : w_head.op;
    assign trace_rd_out     = w_empty ? '0 : w_head.rd;
    assign trace_data_out   = w_empty ? '0 : w_head.data;
    assign trace_we_out     = !w_empty && w_head.we;
    assign trace_check_out  = !w_empty && w_head.chk;
    assign count_out        = r_wr_ptr - r_rd_ptr;
    assign overflow_out     = r_overflow;
    assign dropped_out      = r_dropped;
endmodule
